// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter feeding one UART transmitter from four byte sources.
// Define UART_ARB_TIMEOUT_EN to enable the WAIT_DONE watchdog and the sticky timeout_err flag.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_last,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_done,
  output logic        timeout_err
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [1:0]      last_grant, last_grant_nxt;
  logic            pkt_last, pkt_last_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic [3:0]      grant_nxt;
  logic [3:0]      ready_nxt;
  logic [7:0]      tx_data_nxt;
  logic            tx_valid_nxt;
  logic [1:0]      pick_c;
  logic            found_c;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0]   to_cnt, to_cnt_nxt;
  logic            timeout_nxt;
`else
  logic            unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pick_c  = last_grant;
    found_c = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found_c && req_valid[last_grant + 2'(k)]) begin
        pick_c  = last_grant + 2'(k);
        found_c = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    last_grant_nxt = last_grant;
    pkt_last_nxt   = pkt_last;
    gap_cnt_nxt    = gap_cnt;
    grant_nxt      = grant;
    ready_nxt      = '0;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_valid;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_nxt     = to_cnt;
    timeout_nxt    = timeout_err;
`endif
    unique case (state)
      IDLE: begin
        grant_nxt = '0;
        if (found_c) begin
          idx_nxt   = pick_c;
          grant_nxt = 4'b0001 << pick_c;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[idx]) begin
          tx_data_nxt    = req_data[{idx, 3'b000} +: 8];
          tx_valid_nxt   = 1'b1;
          pkt_last_nxt   = req_last[idx];
          ready_nxt[idx] = 1'b1;
          state_nxt      = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_nxt     = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          tx_valid_nxt = 1'b0;
          gap_cnt_nxt  = '0;
          state_nxt    = GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Abandon the packet; the owner still counts as served for rotation.
        else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tx_valid_nxt   = 1'b0;
          timeout_nxt    = 1'b1;
          last_grant_nxt = idx;
          grant_nxt      = '0;
          state_nxt      = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
`endif
      end
      GAP: begin
        if (!tx_done) begin
          if (32'(gap_cnt) + 32'd1 >= GAP_CYCLES) begin
            if (pkt_last) begin
              last_grant_nxt = idx;
              grant_nxt      = '0;
              state_nxt      = IDLE;
            end else begin
              state_nxt = LOAD;
            end
          end else begin
            gap_cnt_nxt = gap_cnt + GW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= 2'd3;
      pkt_last   <= 1'b0;
      gap_cnt    <= '0;
      grant      <= '0;
      req_ready  <= '0;
      busy       <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      last_grant <= last_grant_nxt;
      pkt_last   <= pkt_last_nxt;
      gap_cnt    <= gap_cnt_nxt;
      grant      <= grant_nxt;
      req_ready  <= ready_nxt;
      busy       <= (state_nxt != IDLE);
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_nxt;
      timeout_err <= timeout_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a packet-level
// round-robin reference model, with behavioural requester and transmitter models.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_done = 1'b0;
  logic        timeout_err;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .grant(grant), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int proto_viol = 0;

  logic [8:0]  rq [4][$];       // {last, data} bytes still to be offered per requester
  bit          mid [4];
  bit          stall [4];
  bit          stall_en;
  int          n_ready [4];
  int          obs_req [$];
  logic [7:0]  obs_data [$];
  int          obs_cyc [$];
  int          fall_q [$];
  logic        tx_valid_prev;
  bit          tx_auto;
  bit          pend;
  int          wait_left;
  int          hold_left;
  int          hold_fixed;

  function automatic int oh_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      mid[i] = 0; stall[i] = 0; n_ready[i] = 0;
    end
    req_valid = '0; req_last = '0; req_data = '0; tx_done = 1'b0;
    pend = 0; wait_left = 0; hold_left = 0; hold_fixed = 0;
    tx_valid_prev = 1'b0; tx_auto = 1; stall_en = 0;
    obs_req.delete(); obs_data.delete(); obs_cyc.delete(); fall_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: observe at the falling edge, then advance requester and transmitter models.
  task automatic step();
    @(negedge clk);
    cyc++;
    if ($countones(req_ready) > 1 || (req_ready & ~grant) != 4'b0) proto_viol++;
    if (tx_done && tx_valid) proto_viol++;
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        n_ready[i]++;
        if (rq[i].size() > 0) begin
          mid[i] = !rq[i][0][8];
          void'(rq[i].pop_front());
        end else begin
          proto_viol++;
        end
      end
    end
    if (tx_valid && !tx_valid_prev) begin
      obs_req.push_back(oh_idx(grant));
      obs_data.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
    if (tx_done) begin
      hold_left--;
      if (hold_left <= 0) begin
        tx_done = 1'b0;
        fall_q.push_back(cyc);
      end
    end else if (pend) begin
      if (wait_left == 0) begin
        tx_done   = 1'b1;
        hold_left = (hold_fixed > 0) ? hold_fixed : int'($urandom_range(1, 3));
        pend      = 0;
      end else begin
        wait_left--;
      end
    end
    if (tx_auto && tx_valid && !tx_valid_prev) begin
      pend      = 1;
      wait_left = int'($urandom_range(0, 4));
    end
    tx_valid_prev = tx_valid;
    for (int i = 0; i < 4; i++) begin
      stall[i]           = stall_en && mid[i] && ($urandom_range(0, 2) == 0);
      req_valid[i]       = (rq[i].size() > 0) && !stall[i];
      req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
    end
  endtask

  task automatic run_idle(input int bound, output bit ok);
    ok = 0;
    for (int n = 0; n < bound; n++) begin
      step();
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0 &&
          !busy && !tx_done && !pend) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    total++;
    if ({tx_valid, busy, timeout_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got tx_valid/busy/timeout_err=%b want=000", {tx_valid, busy, timeout_err});
    end
    total++;
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++;
    if ({req_ready, grant} !== 8'h00) begin
      bad++; $display("FAIL reset_ready_grant got=%b/%b want=0000/0000", req_ready, grant);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_three_byte();
    bit ok;
    logic [7:0] exp;
    do_reset();
    rq[1].push_back({1'b0, 8'h41}); rq[1].push_back({1'b0, 8'h42}); rq[1].push_back({1'b1, 8'h43});
    run_idle(400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL three_byte_idle got=timeout want=idle"); end
    total++;
    if (obs_data.size() != 3) begin bad++; $display("FAIL three_byte_count got=%0d want=3", obs_data.size()); end
    for (int k = 0; k < obs_data.size() && k < 3; k++) begin
      exp = 8'(8'h41 + k);
      total++;
      if (obs_data[k] !== exp || obs_req[k] != 1) begin
        bad++; $display("FAIL three_byte_%0d got=%0d:%h want=1:%h", k, obs_req[k], obs_data[k], exp);
      end
    end
    total++;
    if (n_ready[1] != 3) begin bad++; $display("FAIL three_byte_ready got=%0d want=3", n_ready[1]); end
    total++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL three_byte_end got grant=%b busy=%b want=0000/0", grant, busy);
    end
  endtask

  task automatic test_all_four();
    bit ok;
    int start;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
    start = cyc + 1;
    run_idle(400, ok);
    total++;
    if (!ok || obs_data.size() != 4) begin
      bad++; $display("FAIL all_four_count got=%0d ok=%0d want=4 ok=1", obs_data.size(), ok);
    end
    total++;
    if (obs_cyc.size() == 0 || obs_cyc[0] - start != 2) begin
      bad++; $display("FAIL first_latency got=%0d want=2", (obs_cyc.size() > 0) ? obs_cyc[0] - start : -1);
    end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      exp = 8'(8'h10 + k);
      total++;
      if (obs_req[k] != k || obs_data[k] !== exp) begin
        bad++; $display("FAIL all_four_%0d got=%0d:%h want=%0d:%h", k, obs_req[k], obs_data[k], k, exp);
      end
    end
  endtask

  task automatic test_lock();
    bit ok;
    int exp_req [4] = '{2, 2, 2, 0};
    logic [7:0] exp_dat [4] = '{8'h21, 8'h22, 8'h23, 8'h05};
    do_reset();
    rq[2].push_back({1'b0, 8'h21}); rq[2].push_back({1'b0, 8'h22}); rq[2].push_back({1'b1, 8'h23});
    for (int n = 0; n < 50 && obs_data.size() == 0; n++) step();
    rq[0].push_back({1'b1, 8'h05});
    run_idle(400, ok);
    total++;
    if (!ok || obs_data.size() != 4) begin
      bad++; $display("FAIL lock_count got=%0d ok=%0d want=4 ok=1", obs_data.size(), ok);
    end
    for (int k = 0; k < obs_data.size() && k < 4; k++) begin
      total++;
      if (obs_req[k] != exp_req[k] || obs_data[k] !== exp_dat[k]) begin
        bad++; $display("FAIL lock_%0d got=%0d:%h want=%0d:%h", k, obs_req[k], obs_data[k], exp_req[k], exp_dat[k]);
      end
    end
    total++;
    if (proto_viol != 0) begin bad++; $display("FAIL lock_protocol got=%0d want=0", proto_viol); end
  endtask

  task automatic test_gap_latency();
    bit ok;
    do_reset();
    hold_fixed = 5;
    rq[0].push_back({1'b0, 8'h31}); rq[0].push_back({1'b1, 8'h32});
    run_idle(400, ok);
    total++;
    if (!ok || obs_cyc.size() != 2 || fall_q.size() < 1) begin
      bad++; $display("FAIL gap_count got=%0d ok=%0d want=2 ok=1", obs_cyc.size(), ok);
    end else begin
      total++;
      if (obs_cyc[1] - fall_q[0] != 3) begin
        bad++; $display("FAIL gap_latency got=%0d want=3", obs_cyc[1] - fall_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    tx_auto = 0;
    rq[2].push_back({1'b1, 8'h77});
    for (int n = 0; n < 20 && !tx_valid; n++) step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_tx_valid got=%b want=0", tx_valid); end
    total++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_state got grant=%b busy=%b want=0000/0", grant, busy);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    rq[3].push_back({1'b1, 8'h33}); rq[0].push_back({1'b1, 8'h30});
    run_idle(400, ok);
    total++;
    if (!ok || obs_req.size() != 2 || obs_req[0] != 0 || obs_req[1] != 3) begin
      bad++; $display("FAIL reset_mid_order got n=%0d first=%0d want n=2 first=0 second=3",
                      obs_req.size(), (obs_req.size() > 0) ? obs_req[0] : -1);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    int exp_req [3] = '{0, 2, 0};
    logic [7:0] exp_dat [3] = '{8'h50, 8'h52, 8'h51};
    do_reset();
    tx_auto = 0;
    rq[0].push_back({1'b1, 8'h50}); rq[0].push_back({1'b1, 8'h51}); rq[2].push_back({1'b1, 8'h52});
    for (int n = 0; n < 20 && obs_cyc.size() == 0; n++) step();
    t0 = (obs_cyc.size() > 0) ? obs_cyc[0] : cyc;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (TMO - 1) step();
    total++;
    if (timeout_err !== 1'b0 || tx_valid !== 1'b1) begin
      bad++; $display("FAIL timeout_early at %0d got err=%b tx_valid=%b want=0/1", cyc - t0, timeout_err, tx_valid);
    end
    step();
    total++;
    if (timeout_err !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0) begin
      bad++; $display("FAIL timeout_fire got err=%b tx_valid=%b busy=%b grant=%b want=1/0/0/0000",
                      timeout_err, tx_valid, busy, grant);
    end
    tx_auto = 1;
    run_idle(400, ok);
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
`else
    repeat (30) step();
    total++;
    if (timeout_err !== 1'b0 || tx_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL no_timeout_wait got err=%b tx_valid=%b busy=%b want=0/1/1", timeout_err, tx_valid, busy);
    end
    tx_done = 1'b1; hold_left = 1; tx_auto = 1;
    run_idle(400, ok);
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL no_timeout_flag got=%b want=0", timeout_err); end
`endif
    total++;
    if (!ok || obs_req.size() != 3) begin
      bad++; $display("FAIL timeout_count got=%0d ok=%0d want=3 ok=1", obs_req.size(), ok);
    end
    for (int k = 0; k < obs_req.size() && k < 3; k++) begin
      total++;
      if (obs_req[k] != exp_req[k] || obs_data[k] !== exp_dat[k]) begin
        bad++; $display("FAIL timeout_order_%0d got=%0d:%h want=%0d:%h", k, obs_req[k], obs_data[k], exp_req[k], exp_dat[k]);
      end
    end
    do_reset();
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", timeout_err); end
  endtask

  task automatic test_random(input int rounds);
    bit ok;
    logic [8:0] src [4][$];
    logic [8:0] b;
    int exp_req [$];
    logic [7:0] exp_dat [$];
    int exp_cnt [4];
    int last, r, npk, len;
    bit found, done;
    for (int rd = 0; rd < rounds; rd++) begin
      do_reset();
      stall_en = 1;
      exp_req.delete(); exp_dat.delete();
      for (int i = 0; i < 4; i++) begin
        exp_cnt[i] = 0;
        npk = int'($urandom_range(0, 3));
        if (i == 0 && npk == 0) npk = 1;
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 4));
          for (int q = 0; q < len; q++) rq[i].push_back({q == len - 1, 8'($urandom)});
        end
        src[i] = rq[i];
      end
      // Reference: whole packets, strict rotation over requesters with pending packets.
      last = 3;
      done = 0;
      while (!done) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          r = (last + k) % 4;
          if (!found && src[r].size() > 0) begin
            found = 1;
            last  = r;
            do begin
              b = src[r].pop_front();
              exp_req.push_back(r); exp_dat.push_back(b[7:0]); exp_cnt[r]++;
            end while (!b[8]);
          end
        end
        done = !found;
      end
      run_idle(4000, ok);
      total++;
      if (!ok || obs_req.size() != exp_req.size()) begin
        bad++; $display("FAIL random_%0d_count got=%0d ok=%0d want=%0d", rd, obs_req.size(), ok, exp_req.size());
      end
      for (int k = 0; k < obs_req.size() && k < exp_req.size(); k++) begin
        total++;
        if (obs_req[k] != exp_req[k] || obs_data[k] !== exp_dat[k]) begin
          bad++; $display("FAIL random_%0d_byte_%0d got=%0d:%h want=%0d:%h", rd, k, obs_req[k], obs_data[k], exp_req[k], exp_dat[k]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (n_ready[i] != exp_cnt[i]) begin
          bad++; $display("FAIL random_%0d_ready_%0d got=%0d want=%0d", rd, i, n_ready[i], exp_cnt[i]);
        end
      end
      total++;
      if (proto_viol != 0) begin bad++; $display("FAIL random_%0d_protocol got=%0d want=0", rd, proto_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_three_byte();
    test_all_four();
    test_lock();
    test_gap_latency();
    test_reset_mid();
    test_timeout();
    test_random(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles inserted after tx_done falls, before the next byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 20000, maximum cycles to wait for tx_done; used only under the macro.
REQ-004 Port: clk  input  1  system clock, rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: req_valid  input  4  per-requester byte valid.
REQ-007 Port: req_last  input  4  per-requester flag: the presented byte ends the packet.
REQ-008 Port: req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-009 Port: req_ready  output  4  one-cycle pulse: the byte of requester i was accepted.
REQ-010 Port: grant  output  4  one-hot owner of the transmitter; 0 when idle.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: tx_data  output  8  byte to the UART transmitter.
REQ-013 Port: tx_valid  output  1  data-ready strobe to the transmitter.
REQ-014 Port: tx_done  input  1  transmitter sampled/finished flag.
REQ-015 Port: timeout_err  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LOAD, WAIT_DONE and GAP.
REQ-017 IDLE: when any req_valid is high, the block SHALL grant round-robin, searching from last_grant+1 mod 4, register grant, and go to LOAD on the next edge.
REQ-018 LOAD: when req_valid[g] is high, the block SHALL register tx_data=req_data[g], tx_valid=1 and the last flag, pulse req_ready[g] for one cycle, and go to WAIT_DONE.
REQ-019 LOAD with req_valid[g] low SHALL hold in LOAD, keeping the packet lock and leaving tx_valid at 0.
REQ-020 WAIT_DONE: on tx_done=1 the block SHALL clear tx_valid on the same edge and go to GAP.
REQ-021 GAP: the block SHALL wait for tx_done=0, then count GAP_CYCLES cycles with a counter that resets on entry to GAP.
REQ-022 At the end of GAP, the block SHALL go to LOAD if the last flag is 0.
REQ-023 At the end of GAP with the last flag set, the block SHALL go to IDLE, set last_grant=g and clear grant.
REQ-024 Requests from non-granted requesters SHALL be ignored until the packet ends; packets are never interleaved.
REQ-025 A single-byte packet (req_last set on its first byte) SHALL return to IDLE after one byte.
REQ-026 Simultaneous requests from all four requesters SHALL be served in strict rotation, one packet each.
REQ-027 The minimum latency SHALL be 2 cycles from req_valid rising in IDLE to tx_valid=1.
REQ-028 At most one bit of req_ready SHALL be high in any cycle.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, tx_valid=0, tx_data=0, req_ready=0, grant=0, busy=0, timeout_err=0, counters=0 and last_grant=3, so the first grant goes to requester 0.
REQ-030 Reset asserted mid-packet SHALL drop tx_valid immediately, without waiting for a clock edge, and discard the packet.

Configuration
REQ-031 With UART_ARB_TIMEOUT_EN defined, WAIT_DONE SHALL count cycles and, after TIMEOUT_CYCLES cycles without tx_done, clear tx_valid, set timeout_err=1, abandon the packet, update last_grant and return to IDLE.
REQ-032 Once set, timeout_err SHALL stay set until reset.
REQ-033 With UART_ARB_TIMEOUT_EN undefined, WAIT_DONE SHALL wait indefinitely and timeout_err SHALL be constant 0.

Verification
REQ-034 Requester 1 sends a 3-byte packet 0x41,0x42,0x43 with the last flag on 0x43 -> tx_data is 0x41,0x42,0x43 in order; 3 req_ready[1] pulses; IDLE after the third GAP.
REQ-035 All four requesters issue 1-byte packets 0x10..0x13 at the same time, starting after reset -> grant order is 0,1,2,3; tx_data order is 0x10,0x11,0x12,0x13.
REQ-036 Requester 2 is mid-packet while requester 0 raises req_valid -> no byte from requester 0 appears until requester 2's last byte completes.
REQ-037 tx_done is held high for 5 cycles after a byte with GAP_CYCLES=2 -> the next tx_valid rises exactly 3 cycles after tx_done falls (2 gap cycles plus 1 LOAD cycle).
REQ-038 rst_n is pulsed low while in WAIT_DONE -> tx_valid goes to 0 without a clock edge; the next grant after release goes to requester 0.
REQ-039 With the macro defined, TIMEOUT_CYCLES=8 and tx_done tied to 0 -> timeout_err=1 at cycle 8 of WAIT_DONE, then IDLE, then the next requester in rotation is granted.
